fu_issue_scheduler: RTL and testbench
=====================================

FU_ISSUE_SCHEDULER -- requirements
Module: fu_issue_scheduler

Interface
REQ-001 SHALL have parameter: N_ENTRIES, 16, reservation-station entry count (power of 2).
REQ-002 SHALL have parameter: IDX_W, 4, log2(N_ENTRIES).
REQ-003 SHALL have parameter: ALU_LAT, 1, cycles FU1/FU2 stay busy after a grant (1..15).
REQ-004 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: entry_ready  in  N_ENTRIES  entry valid with both operands ready.
REQ-007 SHALL have port: entry_is_LS  in  N_ENTRIES  entry is a load/store.
REQ-008 SHALL have port: ls_done  in  1  memory unit finished the FU3 operation.
REQ-009 SHALL have port: stall  in  1  suppress all grants this cycle.
REQ-010 SHALL have port: grant_valid  out  3  per-FU issue strobe, bit0=FU1, bit1=FU2, bit2=FU3.
REQ-011 SHALL have port: grant_idx  out  3*IDX_W  selected entry per FU, FU1 in the LSBs.
REQ-012 SHALL have port: issued_mask  out  N_ENTRIES  one-hot OR of granted entries; the RS frees these entries.
REQ-013 SHALL have port: FU_ready  out  3  FU able to accept this cycle; drives the RS FU1_ready/FU2_ready/FU3_ready inputs.

Function
REQ-014 SHALL keep per-FU state IDLE/BUSY; FU_ready[i] = IDLE, except FU_ready[2] = IDLE | (BUSY & ls_done).
REQ-015 SHALL route non-LS entries only to FU1/FU2 and LS entries only to FU3.
REQ-016 SHALL, combinationally, grant FU1 the first ready non-LS entry scanning upward from alu_ptr with wrap, and FU2 the next such entry after it; with only one FU free, that FU takes the first.
REQ-017 SHALL grant FU3 the first ready LS entry scanning upward from ls_ptr with wrap.
REQ-018 SHALL assert grant_valid[i] only when FU_ready[i], a candidate exists, and stall=0; grant_idx is don't-care when grant_valid is low.
REQ-019 SHALL never grant the same entry to two FUs in one cycle.
REQ-020 SHALL, on a clock edge with an ALU grant, move that FU to BUSY and load its counter with ALU_LAT; BUSY decrements each cycle and returns to IDLE at 0, so a grant at edge t makes FU_ready high again at edge t+ALU_LAT.
REQ-021 SHALL move FU3 to BUSY on a grant and to IDLE on ls_done; ls_done and a new grant in the same cycle leave FU3 BUSY with the new operation.
REQ-022 SHALL ignore ls_done while FU3 is IDLE.
REQ-023 SHALL advance alu_ptr to (last granted ALU idx + 1) mod N_ENTRIES and ls_ptr to (FU3 idx + 1) mod N_ENTRIES; pointers hold when no grant occurs.
REQ-024 SHALL hold all state and assert no grants while stall=1, with ls_done still honoured.

Reset
REQ-025 SHALL on reset low asynchronously set all FUs IDLE, counters 0, alu_ptr=ls_ptr=0; outputs become grant_valid=0, issued_mask=0, FU_ready=3'b111 (combinational from reset state).
REQ-026 SHALL drop any in-flight BUSY when reset asserts mid-operation; ls_done is not awaited after reset.

Configuration
REQ-027 SHALL, with SCHED_PERF_CNT_EN defined, add outputs issue_count (32, total grants summed per cycle, wraps) and stall_cycles (32, cycles with stall=1 and any candidate present), both reset to 0; without it, neither port nor counter exists and behaviour is otherwise identical.

Verification
REQ-028 SHALL cover: after reset, entry_ready=0x0006, entry_is_LS=0 -> FU1 idx1, FU2 idx2, issued_mask=0x0006, alu_ptr=3, FU_ready=3'b100 next cycle.
REQ-029 SHALL cover: alu_ptr=14, ready non-LS entries {15,0} -> FU1 idx15, FU2 idx0 (wrap), alu_ptr=1.
REQ-030 SHALL cover: LS entry 5 granted to FU3, ls_done held low 4 cycles -> FU_ready[2]=0 throughout; ls_done with LS entry 7 ready -> FU3 grant idx7 same cycle.
REQ-031 SHALL cover: ALU_LAT=3, single ALU entry granted at edge t -> FU1 not ready at t+1 and t+2, ready at t+3.
REQ-032 SHALL cover: stall=1 with entries ready -> grant_valid=0, pointers unchanged; reset low while FU3 BUSY -> FU_ready=3'b111 immediately.

Source files
------------

// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler: picks ready RS entries for two ALUs and one load/store unit; optional perf counters under SCHED_PERF_CNT_EN
module fu_issue_scheduler #(
  parameter int N_ENTRIES = 16,
  parameter int IDX_W     = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_ENTRIES-1:0]   entry_ready,
  input  logic [N_ENTRIES-1:0]   entry_is_LS,
  input  logic                   ls_done,
  input  logic                   stall,
  output logic [2:0]             grant_valid,
  output logic [3*IDX_W-1:0]     grant_idx,
  output logic [N_ENTRIES-1:0]   issued_mask,
  output logic [2:0]             FU_ready
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]            issue_count,
  output logic [31:0]            stall_cycles
`endif
);
  logic [2:0]           busy_q, busy_d;
  logic [3:0]           cnt_q [2];
  logic [3:0]           cnt_d [2];
  logic [IDX_W-1:0]     alu_ptr_q, alu_ptr_d, ls_ptr_q, ls_ptr_d;
  logic [N_ENTRIES-1:0] alu_c, ls_c;
  logic [IDX_W:0]       a0, a1, l0;
  logic                 go;

  // First set bit of v scanning upward from p with wrap; MSB flags a hit
  function automatic logic [IDX_W:0] pick(input logic [N_ENTRIES-1:0] v, input logic [IDX_W-1:0] p);
    logic [IDX_W:0]   r;
    logic [IDX_W-1:0] j;
    r = '0;
    for (int k = N_ENTRIES-1; k >= 0; k--) begin
      j = p + IDX_W'(k);
      if (v[j]) r = {1'b1, j};
    end
    return r;
  endfunction

  assign alu_c    = entry_ready & ~entry_is_LS;
  assign ls_c     = entry_ready & entry_is_LS;
  assign go       = reset & ~stall;
  assign FU_ready = {~busy_q[2] | ls_done, ~busy_q[1:0]};

  // Candidate selection and grant outputs; FU2 takes the first ALU pick when FU1 is busy
  always_comb begin
    a0 = pick(alu_c, alu_ptr_q);
    a1 = pick(alu_c & ~(N_ENTRIES'(1) << a0[IDX_W-1:0]), a0[IDX_W-1:0] + IDX_W'(1));
    l0 = pick(ls_c, ls_ptr_q);
    grant_valid[0] = go & FU_ready[0] & a0[IDX_W];
    grant_valid[1] = go & FU_ready[1] & (FU_ready[0] ? a1[IDX_W] : a0[IDX_W]);
    grant_valid[2] = go & FU_ready[2] & l0[IDX_W];
    grant_idx = {l0[IDX_W-1:0], FU_ready[0] ? a1[IDX_W-1:0] : a0[IDX_W-1:0], a0[IDX_W-1:0]};
    issued_mask = '0;
    for (int f = 0; f < 3; f++)
      issued_mask = issued_mask | (grant_valid[f] ? N_ENTRIES'(1) << grant_idx[f*IDX_W +: IDX_W] : '0);
  end

  // Next FU busy state, latency counters and round-robin pointers
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    for (int f = 0; f < 2; f++) begin
      if (grant_valid[f]) begin
        busy_d[f] = 1'b1;
        cnt_d[f]  = 4'(ALU_LAT);
      end else if (busy_q[f] && !stall) begin
        cnt_d[f]  = cnt_q[f] - 4'd1;
        busy_d[f] = cnt_q[f] != 4'd1;
      end
    end
    busy_d[2] = grant_valid[2] | (busy_q[2] & ~ls_done);
    alu_ptr_d = grant_valid[1] ? grant_idx[2*IDX_W-1:IDX_W] + IDX_W'(1) :
                grant_valid[0] ? grant_idx[IDX_W-1:0] + IDX_W'(1) : alu_ptr_q;
    ls_ptr_d  = grant_valid[2] ? grant_idx[3*IDX_W-1:2*IDX_W] + IDX_W'(1) : ls_ptr_q;
  end

  // State registers, cleared asynchronously so in-flight work is dropped on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= '0;
      cnt_q     <= '{default: '0};
      alu_ptr_q <= '0;
      ls_ptr_q  <= '0;
    end else begin
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      alu_ptr_q <= alu_ptr_d;
      ls_ptr_q  <= ls_ptr_d;
    end
  end

`ifdef SCHED_PERF_CNT_EN
  // Grants issued and stalled cycles that had work waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_count  <= '0;
      stall_cycles <= '0;
    end else begin
      issue_count  <= issue_count + 32'(grant_valid[0]) + 32'(grant_valid[1]) + 32'(grant_valid[2]);
      stall_cycles <= stall_cycles + 32'(stall & |entry_ready);
    end
  end
`endif
endmodule

// File: tb/tb_fu_issue_scheduler.sv
// tb_fu_issue_scheduler: directed scoreboard bench for fu_issue_scheduler with ALU_LAT=3
module tb_fu_issue_scheduler;
  logic        clk, reset, ls_done, stall;
  logic [15:0] entry_ready, entry_is_LS, issued_mask;
  logic [2:0]  grant_valid, FU_ready;
  logic [11:0] grant_idx;
  int          n_eval, n_fail;

  typedef struct {
    string       tag;
    logic [2:0]  gv;
    logic [11:0] idx;
    logic [15:0] mask;
    logic [2:0]  rdy;
  } exp_t;
  exp_t sb[$];

  fu_issue_scheduler #(.N_ENTRIES(16), .IDX_W(4), .ALU_LAT(3)) dut (
    .clk(clk), .reset(reset), .entry_ready(entry_ready), .entry_is_LS(entry_is_LS),
    .ls_done(ls_done), .stall(stall), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .issued_mask(issued_mask), .FU_ready(FU_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] er, input logic [15:0] ls,
                      input logic done, input logic st, input logic [2:0] gv,
                      input logic [3:0] i0, input logic [3:0] i1, input logic [3:0] i2,
                      input logic [15:0] m, input logic [2:0] r);
    exp_t e;
    logic [11:0] msk;
    entry_ready = er;
    entry_is_LS = ls;
    ls_done     = done;
    stall       = st;
    msk = {{4{gv[2]}}, {4{gv[1]}}, {4{gv[0]}}};
    e.tag = tag; e.gv = gv; e.idx = {i2, i1, i0} & msk; e.mask = m; e.rdy = r;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    msk = {{4{e.gv[2]}}, {4{e.gv[1]}}, {4{e.gv[0]}}};
    chk(e.tag, "grant_valid", 32'(grant_valid), 32'(e.gv));
    chk(e.tag, "grant_idx", 32'(grant_idx & msk), 32'(e.idx));
    chk(e.tag, "issued_mask", 32'(issued_mask), 32'(e.mask));
    chk(e.tag, "FU_ready", 32'(FU_ready), 32'(e.rdy));
    @(negedge clk);
  endtask

  initial begin
    n_eval = 0;
    n_fail = 0;
    reset = 0;
    step("rst", 16'hFFFF, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b111);
    @(negedge clk);
    reset = 1;
    step("pair12", 16'h0006, 16'h0000, 0, 0, 3'b011, 1, 2, 0, 16'h0006, 3'b111);
    step("lat_t1", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b100);
    step("lat_t2", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b100);
    step("lat_t3", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b100);
    step("ptr3_wrap", 16'h0021, 16'h0000, 0, 0, 3'b011, 5, 0, 0, 16'h0021, 3'b111);
    step("busy_a", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b100);
    step("busy_b", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b100);
    step("busy_c", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b100);
    step("single13", 16'h2000, 16'h0000, 0, 0, 3'b001, 13, 0, 0, 16'h2000, 3'b111);
    step("fu1_busy_a", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b110);
    step("fu1_busy_b", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b110);
    step("fu1_busy_c", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b110);
    step("ptr14_wrap", 16'h8001, 16'h0000, 0, 0, 3'b011, 15, 0, 0, 16'h8001, 3'b111);
    step("wait_a", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b100);
    step("wait_b", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b100);
    step("wait_c", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b100);
    step("ptr1", 16'h0007, 16'h0000, 0, 0, 3'b011, 1, 2, 0, 16'h0006, 3'b111);
    step("ls5", 16'h0020, 16'h0020, 0, 0, 3'b100, 0, 0, 5, 16'h0020, 3'b100);
    step("ls_wait1", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b000);
    step("ls_wait2", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b000);
    step("ls_wait3", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b011);
    step("ls_wait4", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b011);
    step("ls_done7", 16'h0080, 16'h0080, 1, 0, 3'b100, 0, 0, 7, 16'h0080, 3'b111);
    step("ls_busy7", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b011);
    step("ls_done", 16'h0000, 16'h0000, 1, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b111);
    step("done_idle", 16'h0000, 16'h0000, 1, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b111);
    step("idle_hold", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b111);
    step("ls_ptr8", 16'h0208, 16'h0208, 0, 0, 3'b100, 0, 0, 9, 16'h0200, 3'b111);
    step("stall_done", 16'hFFFF, 16'h0F0F, 1, 1, 3'b000, 0, 0, 0, 16'h0000, 3'b111);
    step("stall_idle", 16'hFFFF, 16'h0F0F, 0, 1, 3'b000, 0, 0, 0, 16'h0000, 3'b111);
    step("post_stall", 16'h0C03, 16'h0C00, 0, 0, 3'b111, 0, 1, 10, 16'h0403, 3'b111);
    step("all_busy", 16'h0000, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b000);
    reset = 0;
    step("rst_mid", 16'hFFFF, 16'h0000, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 3'b111);
    reset = 1;
    step("after_rst", 16'h0003, 16'h0000, 0, 0, 3'b011, 0, 1, 0, 16'h0003, 3'b111);
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end
endmodule
